// File: rtl/inst_fetcher_pkg.sv
// Shared types for the instruction fetcher: machine widths, fetch FSM states and
// the buffered entry layout (PC plus instruction word).
package inst_fetcher_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] UIntX;
  typedef logic [ILEN-1:0] Inst;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } FetchState;

  typedef struct packed {
    UIntX addr;
    Inst  bits;
  } FetchEntry;

  localparam int ENTRY_W = $bits(FetchEntry);

  function automatic UIntX align_pc(input UIntX a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetcher_fifo.sv
// Synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
// clear has priority over push/pop.
module inst_fetcher_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding memory read, responses buffered with their PC.
// Optional INST_FETCHER_BYPASS_EN forwards a response straight to the core when the FIFO is empty.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int   FIFO_DEPTH = 2,
  parameter UIntX INITIAL_PC = 64'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic [XLEN-1:0]               mem_addr,
  input  logic                          mem_rvalid,
  input  logic [ILEN-1:0]               mem_rdata,
  output logic                          core_valid,
  input  logic                          core_ready,
  output logic [XLEN-1:0]               core_addr,
  output logic [ILEN-1:0]               core_bits,
  input  logic                          flush,
  input  logic [XLEN-1:0]               flush_addr,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high;
  // valid never depends on ready of the same interface.

  FetchState state_q, state_d;
  UIntX      fetch_pc_q, fetch_pc_d;
  UIntX      req_addr_q, req_addr_d;

  FetchEntry push_entry, head_entry, out_entry;
  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic      bypass_hit;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign push_entry = '{addr: req_addr_q, bits: mem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    mem_valid  = 1'b0;
    fifo_push  = 1'b0;
    bypass_hit = 1'b0;
    case (state_q)
      REQ: begin
        // Room is judged on the registered count; a same-cycle pop does not count.
        mem_valid = !fifo_full && !flush && !rst;
        if (mem_valid && mem_ready) begin
          req_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + UIntX'(4);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = REQ;
`ifdef INST_FETCHER_BYPASS_EN
          bypass_hit = fifo_empty && !flush;
          fifo_push  = !(bypass_hit && core_ready);
`else
          fifo_push  = 1'b1;
`endif
        end
      end
      DISCARD: begin
        if (mem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (flush) begin
      fifo_push  = 1'b0;
      fetch_pc_d = align_pc(flush_addr);
      // A response still owed by memory must be swallowed before issuing again.
      state_d    = ((state_q == WAIT || state_q == DISCARD) && !mem_rvalid) ? DISCARD : REQ;
    end
  end

  assign fifo_pop   = !rst && !fifo_empty && core_ready && !flush;
  assign core_valid = !rst && (!fifo_empty || bypass_hit);
  assign out_entry  = bypass_hit ? push_entry : head_entry;
  assign core_addr  = core_valid ? out_entry.addr : '0;
  assign core_bits  = core_valid ? out_entry.bits : '0;
  assign mem_addr   = fetch_pc_q;

  assign dbg_state      = state_q;
  assign dbg_fifo_count = fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= INITIAL_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  inst_fetcher_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: memory responder, request/delivery scoreboard,
// and cycle-exact probes around reset, backpressure, flush and address wrap.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready, mem_rvalid;
  logic [63:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        core_valid, core_ready;
  logic [63:0] core_addr;
  logic [31:0] core_bits;
  logic        flush;
  logic [63:0] flush_addr;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_fifo_count;

  int n_vec = 0;
  int n_err = 0;
  int accept_cnt = 0;
  int resp_lat = 1;
  logic [31:0] resp_data = 32'h0;
  int base;

  logic [63:0] exp_req_q[$];
  logic [95:0] exp_core_q[$];

  inst_fetcher #(.FIFO_DEPTH(2), .INITIAL_PC(64'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .core_valid     (core_valid),
    .core_ready     (core_ready),
    .core_addr      (core_addr),
    .core_bits      (core_bits),
    .flush          (flush),
    .flush_addr     (flush_addr),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; mem_ready = 1'b0; core_ready = 1'b0; flush = 1'b0; flush_addr = '0;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  // memory responder: one response per accepted request, resp_lat cycles later
  initial begin
    int lat;
    logic [31:0] d;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_valid && mem_ready) begin
        lat = resp_lat;
        d   = resp_data;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 mem_rvalid = 1'b1; mem_rdata = d;
        @(posedge clk);
        #1 mem_rvalid = 1'b0; mem_rdata = '0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_valid && mem_ready) begin
          accept_cnt++;
          if (exp_req_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL req_unexpected: got addr %h expected none", mem_addr);
          end else begin
            check("req_addr", 96'(mem_addr), 96'(exp_req_q.pop_front()));
          end
        end
        if (core_valid && core_ready && !flush) begin
          if (exp_core_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL core_unexpected: got %h/%h expected none", core_addr, core_bits);
          end else begin
            check("core_entry", {core_addr, core_bits}, exp_core_q.pop_front());
          end
        end
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1; mem_ready = 1'b0; core_ready = 1'b0; flush = 1'b0; flush_addr = '0;
    repeat (2) step();
    probe();
    check("rst_mem_valid",  96'(mem_valid),  96'd0);
    check("rst_core_valid", 96'(core_valid), 96'd0);
    check("rst_core_addr",  96'(core_addr),  96'd0);
    check("rst_core_bits",  96'(core_bits),  96'd0);
    check("rst_state",      96'(dbg_state),  96'(REQ));
    check("rst_count",      96'(dbg_fifo_count), 96'd0);
    step();
    rst = 1'b0;
    base = accept_cnt;
  endtask

  task automatic wait_accepts(input int target);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (accept_cnt < target && guard < 60);
    mem_ready = 1'b0;
    check("accepts_reached", 96'(accept_cnt), 96'(target));
  endtask

  task automatic drain();
    mem_ready = 1'b0; core_ready = 1'b1; flush = 1'b0;
    repeat (8) step();
    check("req_q_empty",  96'(exp_req_q.size()),  96'd0);
    check("core_q_empty", 96'(exp_core_q.size()), 96'd0);
    exp_req_q.delete();
    exp_core_q.delete();
  endtask

  initial begin
    // T1: streaming fetch with latency probes
    reset_dut();
    resp_data = 32'h00000013; resp_lat = 1;
    exp_req_q = '{64'h0, 64'h4, 64'h8};
    exp_core_q = '{{64'h0, 32'h13}, {64'h4, 32'h13}, {64'h8, 32'h13}};
    mem_ready = 1'b1; core_ready = 1'b1;
    probe();
    check("t1_req_valid", 96'(mem_valid), 96'd1);
    check("t1_req_addr",  96'(mem_addr),  96'h0);
    check("t1_core_idle", 96'(core_valid), 96'd0);
    step(); probe();
`ifdef INST_FETCHER_BYPASS_EN
    check("t1_bypass_valid", 96'(core_valid), 96'd1);
    check("t1_bypass_addr",  96'(core_addr),  96'h0);
    check("t1_bypass_count", 96'(dbg_fifo_count), 96'd0);
    step(); probe();
    check("t1_after_bypass_valid", 96'(core_valid), 96'd0);
`else
    check("t1_n1_core_valid", 96'(core_valid), 96'd0);
    step(); probe();
    check("t1_n2_core_valid", 96'(core_valid), 96'd1);
    check("t1_n2_core_addr",  96'(core_addr),  96'h0);
    check("t1_n2_core_bits",  96'(core_bits),  96'h13);
`endif
    wait_accepts(base + 3);
    drain();

    // T2: backpressure fills the FIFO, then resumes without gap or duplicate
    reset_dut();
    resp_data = 32'h00000093; resp_lat = 1;
    exp_req_q = '{64'h0, 64'h4, 64'h8, 64'hC};
    exp_core_q = '{{64'h0, 32'h93}, {64'h4, 32'h93}, {64'h8, 32'h93}, {64'hC, 32'h93}};
    mem_ready = 1'b1; core_ready = 1'b0;
    repeat (10) step();
    probe();
    check("t2_accepts",    96'(accept_cnt - base), 96'd2);
    check("t2_mem_valid",  96'(mem_valid),  96'd0);
    check("t2_count_full", 96'(dbg_fifo_count), 96'd2);
    check("t2_core_valid", 96'(core_valid), 96'd1);
    check("t2_head_addr",  96'(core_addr),  96'h0);
    step();
    core_ready = 1'b1;
    wait_accepts(base + 4);
    drain();

    // T3: flush while waiting; late response is discarded
    reset_dut();
    resp_data = 32'hDEADBEEF; resp_lat = 3;
    exp_req_q = '{64'h0, 64'h1000};
    exp_core_q = '{{64'h1000, 32'h00A00093}};
    mem_ready = 1'b1; core_ready = 1'b1;
    step();
    mem_ready = 1'b0; flush = 1'b1; flush_addr = 64'h1003;
    probe();
    check("t3_flush_no_req", 96'(mem_valid), 96'd0);
    step();
    flush = 1'b0; resp_data = 32'h00A00093; resp_lat = 1;
    probe();
    check("t3_discard_state", 96'(dbg_state), 96'(DISCARD));
    check("t3_core_idle",     96'(core_valid), 96'd0);
    step();
    mem_ready = 1'b1;
    probe();
    check("t3_drop_core_idle", 96'(core_valid), 96'd0);
    check("t3_drop_count",     96'(dbg_fifo_count), 96'd0);
    check("t3_drop_no_req",    96'(mem_valid), 96'd0);
    step(); probe();
    check("t3_state_req",  96'(dbg_state), 96'(REQ));
    check("t3_req_valid",  96'(mem_valid), 96'd1);
    check("t3_req_addr",   96'(mem_addr),  96'h1000);
    wait_accepts(base + 2);
    drain();

    // T4: flush coincides with the response
    reset_dut();
    resp_data = 32'h11111111; resp_lat = 1;
    exp_req_q = '{64'h0, 64'h2000};
    exp_core_q = '{{64'h2000, 32'h22222222}};
    mem_ready = 1'b1; core_ready = 1'b1;
    step();
    flush = 1'b1; flush_addr = 64'h2000;
    probe();
    check("t4_core_idle", 96'(core_valid), 96'd0);
    step();
    flush = 1'b0; resp_data = 32'h22222222;
    probe();
    check("t4_state_req", 96'(dbg_state), 96'(REQ));
    check("t4_req_valid", 96'(mem_valid), 96'd1);
    check("t4_req_addr",  96'(mem_addr),  96'h2000);
    wait_accepts(base + 2);
    drain();

    // T5: stalled request stays stable, then PC wraps to zero
    reset_dut();
    resp_data = 32'h00000073; resp_lat = 1;
    exp_req_q = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    exp_core_q = '{{64'hFFFF_FFFF_FFFF_FFFC, 32'h73}, {64'h0, 32'h73}};
    mem_ready = 1'b0; core_ready = 1'b1;
    flush = 1'b1; flush_addr = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      probe();
      check("t5_stall_valid", 96'(mem_valid), 96'd1);
      check("t5_stall_addr",  96'(mem_addr),  96'hFFFF_FFFF_FFFF_FFFC);
      step();
    end
    mem_ready = 1'b1;
    wait_accepts(base + 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
